time_counter: RTL and testbench

- Registered minutes:seconds counter for the stopwatch datapath; successor to the combinational next-time logic.
- Holds the time state and advances it on external tick enables.
- Supports a normal mode and an adjust mode; in adjust mode either field can be selected.
- Adds run/pause control, synchronous clear, a wrap pulse, and parametrised field widths and limits.

---
 rtl/time_counter.sv | 98 +++++++++
 tb/tb_time_counter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/time_counter.sv
// Registered minutes:seconds stopwatch counter with run/pause control,
// adjust mode, synchronous clear and a full-rollover wrap pulse.
//
// state  | meaning
// -------+----------------------------------------------------
// RUN    | normal ticks advance the time
// PAUSED | normal ticks ignored; adjust mode still operates
module time_counter #(
    parameter int SEC_W   = 6,
    parameter int MIN_W   = 6,
    parameter int SEC_MAX = 59,
    parameter int MIN_MAX = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_norm,
    input  logic             tick_adj,
    input  logic             adj,
    input  logic             sel,
    input  logic             pause_pulse,
    input  logic             clear_pulse,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic             running,
    output logic             wrap
);

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [SEC_W-1:0] sec_nxt, sec_inc;
    logic [MIN_W-1:0] min_nxt, min_inc;
    logic             wrap_nxt;
    logic             sec_last, min_last;

    // >= rather than == so an out-of-range field still recovers to zero
    assign sec_last = (seconds >= SEC_W'(SEC_MAX));
    assign min_last = (minutes >= MIN_W'(MIN_MAX));
    assign sec_inc  = sec_last ? '0 : seconds + SEC_W'(1);
    assign min_inc  = min_last ? '0 : minutes + MIN_W'(1);

    assign running = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (pause_pulse) begin
            state_nxt = (state == RUN) ? PAUSED : RUN;
        end
    end

    always_comb begin
        sec_nxt  = seconds;
        min_nxt  = minutes;
        wrap_nxt = 1'b0;
        if (clear_pulse) begin
            sec_nxt = '0;
            min_nxt = '0;
        end else if (adj) begin
            if (tick_adj) begin
                if (sel) begin
                    min_nxt = min_inc;
                end else begin
                    sec_nxt = sec_inc;
                end
            end
        end else if (tick_norm && state == RUN) begin
            sec_nxt = sec_inc;
            if (sec_last) begin
                min_nxt  = min_inc;
                wrap_nxt = min_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seconds <= '0;
            minutes <= '0;
            wrap    <= 1'b0;
        end else begin
            seconds <= sec_nxt;
            minutes <= min_nxt;
            wrap    <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter: a vector table for single-cycle
// behaviour plus hand sequences for rollover, adjust, reset and a small instance.
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_norm = 1'b0, tick_adj = 1'b0, adj = 1'b0, sel = 1'b0;
    logic       pause_pulse = 1'b0, clear_pulse = 1'b0;
    logic [5:0] seconds, minutes;
    logic       running, wrap;

    logic       s_tick = 1'b0;
    logic [3:0] s_seconds;
    logic [1:0] s_minutes;
    logic       s_running, s_wrap;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    time_counter dut (
        .clk(clk), .rst_n(rst_n), .tick_norm(tick_norm), .tick_adj(tick_adj),
        .adj(adj), .sel(sel), .pause_pulse(pause_pulse), .clear_pulse(clear_pulse),
        .seconds(seconds), .minutes(minutes), .running(running), .wrap(wrap)
    );

    time_counter #(.SEC_W(4), .MIN_W(2), .SEC_MAX(9), .MIN_MAX(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .tick_norm(s_tick), .tick_adj(1'b0),
        .adj(1'b0), .sel(1'b0), .pause_pulse(1'b0), .clear_pulse(1'b0),
        .seconds(s_seconds), .minutes(s_minutes), .running(s_running), .wrap(s_wrap)
    );

    typedef struct {
        logic tn, ta, a, s, p, c;
        int   e_sec, e_min;
        logic e_run, e_wrap;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_time(input string name, input int e_min, input int e_sec,
                            input int e_run, input int e_wrap);
        chk({name, " seconds"}, seconds, e_sec);
        chk({name, " minutes"}, minutes, e_min);
        chk({name, " running"}, running, e_run);
        chk({name, " wrap"}, wrap, e_wrap);
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 ns later, drop pulses
    task automatic step(input logic tn, input logic ta, input logic a, input logic s,
                        input logic p, input logic c);
        tick_norm = tn; tick_adj = ta; adj = a; sel = s;
        pause_pulse = p; clear_pulse = c;
        @(posedge clk);
        #1;
        tick_norm = 1'b0; tick_adj = 1'b0; pause_pulse = 1'b0; clear_pulse = 1'b0;
    endtask

    task automatic adj_ticks(input logic s, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, s, 1'b0, 1'b0);
    endtask

    vec_t vecs[16];
    int   wrap_cnt;

    initial begin
        //           tn    ta    a     s     p     c     sec min run   wrap
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4, 0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5, 1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, 1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7, 1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b1, 1'b0};

        #12;
        chk_time("reset", 0, 0, 1, 0);
        chk("small reset seconds", s_seconds, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].tn, vecs[i].ta, vecs[i].a, vecs[i].s, vecs[i].p, vecs[i].c);
            chk_time($sformatf("vec%0d", i), vecs[i].e_min, vecs[i].e_sec,
                     vecs[i].e_run, vecs[i].e_wrap);
        end

        // 00:59 -> 01:00
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        adj_ticks(1'b0, 59);
        chk_time("set 00:59", 0, 59, 1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("carry 01:00", 1, 0, 1, 0);

        // 59:59 -> 00:00 with a single wrap pulse
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        adj_ticks(1'b1, 59);
        adj_ticks(1'b0, 59);
        chk_time("set 59:59", 59, 59, 1, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("rollover", 0, 0, 1, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("wrap one cycle", 0, 0, 1, 0);

        // seconds adjust from 05:58, no carry into minutes
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        adj_ticks(1'b1, 5);
        adj_ticks(1'b0, 58);
        adj_ticks(1'b0, 1);
        chk_time("adj sec 1", 5, 59, 1, 0);
        adj_ticks(1'b0, 1);
        chk_time("adj sec 2", 5, 0, 1, 0);
        adj_ticks(1'b0, 1);
        chk_time("adj sec 3", 5, 1, 1, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("adj ignores norm", 5, 1, 1, 0);

        // minutes adjust from 58:10
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        adj_ticks(1'b0, 10);
        adj_ticks(1'b1, 58);
        adj_ticks(1'b1, 1);
        chk_time("adj min 1", 59, 10, 1, 0);
        adj_ticks(1'b1, 1);
        chk_time("adj min 2", 0, 10, 1, 0);

        // paused hold, adjust while paused, resume
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("paused hold", 0, 10, 0, 0);
        adj_ticks(1'b0, 1);
        chk_time("paused adj", 0, 11, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_time("resume", 0, 12, 1, 0);

        // 12:34 with clear + pause + tick together
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        adj_ticks(1'b1, 12);
        adj_ticks(1'b0, 34);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_time("clear combo", 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // asynchronous reset mid-count at 07:42 while paused
        adj_ticks(1'b1, 7);
        adj_ticks(1'b0, 42);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_time("at 07:42 paused", 7, 42, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_time("async reset", 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // small instance: 30 ticks is one full cycle of 3 minutes x 10 seconds
        wrap_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            s_tick = 1'b1;
            @(posedge clk);
            #1;
            s_tick = 1'b0;
            if (s_wrap) wrap_cnt++;
            if (i == 28) chk("small at 2:9 seconds", s_seconds, 9);
        end
        chk("small seconds", s_seconds, 0);
        chk("small minutes", s_minutes, 0);
        chk("small wrap on last tick", s_wrap, 1);
        chk("small wrap count", wrap_cnt, 1);
        @(posedge clk);
        #1;
        chk("small wrap drops", s_wrap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
